lsu: RTL

Load/store unit between the execute stage and the byte-addressed data RAM. Accepts one memory request per handshake, checks alignment and range, drives the RAM's write/read port for exactly one cycle, then returns a sign- or zero-extended load result or a store acknowledgement. Faulting requests never reach the RAM.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/load_extend.sv | 22 ++
 rtl/lsu.sv | 116 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, RAM byte-select encodings, FSM states and access-size helpers for the LSU.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_BYTE = 2'd0;
    localparam logic [1:0] SEL_HALF = 2'd1;
    localparam logic [1:0] SEL_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // funct3[1:0] encodes the width for every legal load and store
    function automatic logic [1:0] sel_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SEL_BYTE;
            2'b01:   return SEL_HALF;
            default: return SEL_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the RAM read word for a load; purely combinational.
// No latency and no flow control: the caller samples the result when it needs it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] data
);

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{word[7]}}, word[7:0]};
            F3_LBU:  data = {24'b0, word[7:0]};
            F3_LH:   data = {{16{word[15]}}, word[15:0]};
            F3_LHU:  data = {16'b0, word[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, one RAM access cycle, faults skip the RAM entirely.
// Response 2 cycles after the request (1 for faults); holds the response until rsp_ready, no new request meanwhile.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic        ram_en,
    output logic        ram_we,
    output logic [1:0]  ram_byte_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] ext_data;
    logic        f3_ok;
    logic        misaligned;
    logic [32:0] end_addr;
    logic        req_fault;

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            F3_LB, F3_LH, F3_LW: f3_ok = 1'b1;
            F3_LBU, F3_LHU:      f3_ok = !req_store;
            default:             f3_ok = 1'b0;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr   = {1'b0, req_addr} + 33'(size_of(req_funct3));
    assign misaligned = (sel_of(req_funct3) == SEL_HALF && req_addr[0]) ||
                        (sel_of(req_funct3) == SEL_WORD && req_addr[1:0] != 2'b00);
    assign req_fault  = !f3_ok || misaligned || (end_addr > 33'(ADDR_LIMIT));

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .word   (ram_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_fault    <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_byte_sel <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            store_q      <= 1'b0;
            funct3_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        store_q      <= req_store;
                        funct3_q     <= req_funct3;
                        ram_addr     <= req_addr;
                        ram_byte_sel <= sel_of(req_funct3);
                        ram_wdata    <= req_wdata;
                        if (req_fault) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end else begin
                            ram_en <= 1'b1;
                            ram_we <= req_store;
                            state  <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_data  <= store_q ? 32'd0 : ext_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_fault <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
